// File: rtl/axilite_s_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS x 32-bit registers behind independent write and read FSMs.
// Define AXIL_S_DECERR_EN to answer out-of-range addresses with DECERR instead of aliasing them.
module axilite_s_regbank #(
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp
);

  localparam int         IDX_W       = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {WIDLE, WAIT_W, WAIT_AW, WRESP} wstate_e;
  typedef enum logic       {RIDLE, RDATA} rstate_e;

  logic [31:0] regs [NUM_REGS];

  // Address decode
  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             aw_err, ar_err;
  logic             unused_addr_bits;

  assign aw_idx = s_axi_awaddr[IDX_W+1:2];
  assign ar_idx = s_axi_araddr[IDX_W+1:2];
`ifdef AXIL_S_DECERR_EN
  assign aw_err = |s_axi_awaddr[ADDR_W-1:IDX_W+2];
  assign ar_err = |s_axi_araddr[ADDR_W-1:IDX_W+2];
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif
  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                              s_axi_awaddr[ADDR_W-1:IDX_W+2], s_axi_araddr[ADDR_W-1:IDX_W+2]};

  // Handshakes only count once the registered ready is high, so the first
  // cycle after reset release never accepts anything.
  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // ---------------- write channel ----------------
  wstate_e          w_state_q, w_state_d;
  logic             awready_d, wready_d, bvalid_d;
  logic [1:0]       bresp_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic             aw_err_q, aw_err_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             wr_go, wr_err;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;

  always_comb begin
    // NOTE: every comb output gets a default first; a path that skips an assignment would infer a latch.
    w_state_d = w_state_q;
    awready_d = s_axi_awready;
    wready_d  = s_axi_wready;
    bvalid_d  = s_axi_bvalid;
    bresp_d   = s_axi_bresp;
    aw_idx_d  = aw_idx_q;
    aw_err_d  = aw_err_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wr_go     = 1'b0;
    wr_idx    = aw_idx;
    wr_err    = aw_err;
    wr_data   = s_axi_wdata;
    wr_strb   = s_axi_wstrb;
    case (w_state_q)
      WIDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b1;
        if (aw_hs && w_hs) begin
          wr_go     = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end else if (aw_hs) begin
          aw_idx_d  = aw_idx;
          aw_err_d  = aw_err;
          awready_d = 1'b0;
          w_state_d = WAIT_W;
        end else if (w_hs) begin
          wdata_d   = s_axi_wdata;
          wstrb_d   = s_axi_wstrb;
          wready_d  = 1'b0;
          w_state_d = WAIT_AW;
        end
      end
      WAIT_W: if (w_hs) begin
        wr_go    = 1'b1;
        wr_idx   = aw_idx_q;
        wr_err   = aw_err_q;
        wready_d = 1'b0;
      end
      WAIT_AW: if (aw_hs) begin
        wr_go     = 1'b1;
        wr_data   = wdata_q;
        wr_strb   = wstrb_q;
        awready_d = 1'b0;
      end
      WRESP: if (s_axi_bready) begin
        bvalid_d  = 1'b0;
        bresp_d   = RESP_OKAY;
        awready_d = 1'b1;
        wready_d  = 1'b1;
        w_state_d = WIDLE;
      end
      default: w_state_d = WIDLE;
    endcase
    if (wr_go) begin
      bvalid_d  = 1'b1;
      bresp_d   = wr_err ? RESP_DECERR : RESP_OKAY;
      w_state_d = WRESP;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_q     <= WIDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_idx_q      <= '0;
      aw_err_q      <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      w_state_q     <= w_state_d;
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      s_axi_bvalid  <= bvalid_d;
      s_axi_bresp   <= bresp_d;
      aw_idx_q      <= aw_idx_d;
      aw_err_q      <= aw_err_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
    end
  end

  // NOTE: the register file is reset explicitly because software relies on reading zeros after reset.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_go && !wr_err) begin
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  rstate_e     r_state_q, r_state_d;
  logic        arready_d, rvalid_d;
  logic [31:0] rdata_d;
  logic [1:0]  rresp_d;

  // Reads sample regs before this edge's write lands, so a same-edge collision returns the old value.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = s_axi_arready;
    rvalid_d  = s_axi_rvalid;
    rdata_d   = s_axi_rdata;
    rresp_d   = s_axi_rresp;
    case (r_state_q)
      RIDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = ar_err ? '0 : regs[ar_idx];
          rresp_d   = ar_err ? RESP_DECERR : RESP_OKAY;
          r_state_d = RDATA;
        end
      end
      RDATA: if (s_axi_rready) begin
        rvalid_d  = 1'b0;
        rdata_d   = '0;
        rresp_d   = RESP_OKAY;
        arready_d = 1'b1;
        r_state_d = RIDLE;
      end
      default: r_state_d = RIDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state_q     <= RIDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      r_state_q     <= r_state_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rdata   <= rdata_d;
      s_axi_rresp   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axilite_s_regbank.sv
// Directed scoreboard bench for axilite_s_regbank; expectations follow AXIL_S_DECERR_EN when defined.
module tb_axilite_s_regbank;

  localparam int NREGS = 16;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;

  axilite_s_regbank #(.ADDR_W(32), .NUM_REGS(NREGS)) dut (
    .s_axi_aclk    (aclk),
    .s_axi_aresetn (aresetn),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [NREGS];
  logic [1:0]  exp_b [$];
  rexp_t       exp_r [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
    bit decode_on;
`ifdef AXIL_S_DECERR_EN
    decode_on = 1'b1;
`else
    decode_on = 1'b0;
`endif
    return decode_on && (a[31:6] != '0);
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    return addr_err(a) ? 2'b11 : 2'b00;
  endfunction

  function automatic rexp_t model_read(input logic [31:0] a);
    rexp_t r;
    r.data = addr_err(a) ? 32'h0 : model[a[5:2]];
    r.resp = model_resp(a);
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!addr_err(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  // Waits for the edge that completes a handshake on channel ch (0=AW, 1=W, 2=AR).
  task automatic wait_ready(input int ch, input string tag);
    logic rdy;
    rdy = 1'b0;
    for (int n = 0; n < 20; n++) begin
      rdy = (ch == 0) ? s_axi_awready : (ch == 1) ? s_axi_wready : s_axi_arready;
      @(posedge aclk); #1;
      if (rdy) break;
    end
    if (rdy !== 1'b1) check({tag, "_timeout"}, {31'b0, rdy}, 32'd1);
  endtask

  task automatic collect_b(input string tag);
    logic [1:0] e;
    for (int n = 0; n < 20 && s_axi_bvalid !== 1'b1; n++) begin
      @(posedge aclk); #1;
    end
    check({tag, "_bvalid"}, {31'b0, s_axi_bvalid}, 32'd1);
    e = exp_b.pop_front();
    check({tag, "_bresp"}, {30'b0, s_axi_bresp}, {30'b0, e});
    s_axi_bready = 1'b1;
    @(posedge aclk); #1;
    check({tag, "_bdone"}, {29'b0, s_axi_bvalid, s_axi_awready, s_axi_wready}, 32'b011);
  endtask

  task automatic collect_r(input string tag);
    rexp_t e;
    for (int n = 0; n < 20 && s_axi_rvalid !== 1'b1; n++) begin
      @(posedge aclk); #1;
    end
    check({tag, "_rvalid"}, {31'b0, s_axi_rvalid}, 32'd1);
    e = exp_r.pop_front();
    check({tag, "_rdata"}, s_axi_rdata, e.data);
    check({tag, "_rresp"}, {30'b0, s_axi_rresp}, {30'b0, e.resp});
    s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    check({tag, "_rdone"}, {30'b0, s_axi_rvalid, s_axi_arready}, 32'b01);
    check({tag, "_rdata0"}, s_axi_rdata, 32'h0);
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    exp_b.push_back(model_resp(a));
    model_write(a, d, s);
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    wait_ready(0, tag);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check({tag, "_blat"}, {31'b0, s_axi_bvalid}, 32'd1);
    collect_b(tag);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a);
    exp_r.push_back(model_read(a));
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    wait_ready(2, tag);
    s_axi_arvalid = 1'b0;
    check({tag, "_rlat"}, {31'b0, s_axi_rvalid}, 32'd1);
    collect_r(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] eb;
    rexp_t      er;

    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    aresetn       = 1'b0;
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0;
    s_axi_wvalid  = 1'b0; s_axi_wdata  = '0; s_axi_wstrb = '0;
    s_axi_bready  = 1'b1;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0;
    s_axi_rready  = 1'b1;

    // Reset values, then readies rise on the first edge after release.
    #1;
    check("rst_ctrl", {27'b0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}, 32'h0);
    check("rst_resp", {28'b0, s_axi_bresp, s_axi_rresp}, 32'h0);
    check("rst_rdata", s_axi_rdata, 32'h0);
    repeat (3) @(posedge aclk);
    #2 aresetn = 1'b1;
    @(posedge aclk); #1;
    check("rel_ready", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'b111);

    // 1: AW+W together, read back.
    do_write("t1w", 32'h08, 32'hDEADBEEF, 4'hF);
    do_read("t1r", 32'h08);

    // 2: byte strobes, plus an all-zero strobe that must change nothing.
    do_write("t2a", 32'h04, 32'h11223344, 4'hF);
    do_write("t2b", 32'h04, 32'hAABBCCDD, 4'h5);
    do_read("t2r", 32'h04);
    do_write("t2z", 32'h08, 32'hFFFFFFFF, 4'h0);
    do_read("t2zr", 32'h08);

    // 3: W arrives well before AW.
    exp_b.push_back(model_resp(32'h0C));
    model_write(32'h0C, 32'hCAFEF00D, 4'hF);
    s_axi_wdata  = 32'hCAFEF00D;
    s_axi_wstrb  = 4'hF;
    s_axi_wvalid = 1'b1;
    wait_ready(1, "t3w");
    s_axi_wvalid = 1'b0;
    check("t3_after_w", {29'b0, s_axi_wready, s_axi_awready, s_axi_bvalid}, 32'b010);
    for (int i = 0; i < 2; i++) begin
      @(posedge aclk); #1;
      check("t3_wait", {30'b0, s_axi_awready, s_axi_bvalid}, 32'b10);
    end
    s_axi_awaddr  = 32'h0C;
    s_axi_awvalid = 1'b1;
    wait_ready(0, "t3aw");
    s_axi_awvalid = 1'b0;
    check("t3_blat", {31'b0, s_axi_bvalid}, 32'd1);
    collect_b("t3");
    do_read("t3r", 32'h0C);

    // 4: B and R backpressure; also same-edge read/write collisions on reg 4.
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    exp_r.push_back(model_read(32'h10));
    exp_b.push_back(model_resp(32'h10));
    model_write(32'h10, 32'h01020304, 4'hF);
    s_axi_awaddr = 32'h10; s_axi_wdata = 32'h01020304; s_axi_wstrb = 4'hF;
    s_axi_araddr = 32'h10;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    wait_ready(0, "t4a");
    exp_r.push_back(model_read(32'h10));
    exp_b.push_back(model_resp(32'h10));
    model_write(32'h10, 32'hA5A55A5A, 4'hF);
    s_axi_wdata = 32'hA5A55A5A;
    eb = exp_b.pop_front();
    er = exp_r.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("t4_b_hold", {29'b0, s_axi_bvalid, s_axi_bresp}, {29'b0, 1'b1, eb});
      check("t4_r_hold", {29'b0, s_axi_rvalid, s_axi_rresp}, {29'b0, 1'b1, er.resp});
      check("t4_rdata_hold", s_axi_rdata, er.data);
      check("t4_no_accept", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'b000);
      @(posedge aclk); #1;
    end
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    check("t4_release", {27'b0, s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_arready},
          32'b00111);
    s_axi_rready = 1'b0;
    wait_ready(0, "t4b");
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    check("t4_lat2", {30'b0, s_axi_bvalid, s_axi_rvalid}, 32'b11);
    collect_b("t4b");
    collect_r("t4r");
    do_read("t4r2", 32'h10);

    // 5: address beyond the register file.
    do_write("t5w", 32'h40, 32'h00000055, 4'hF);
    do_read("t5r40", 32'h40);
    do_read("t5r00", 32'h00);

    // 6: asynchronous reset while both responses are pending.
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    s_axi_awaddr = 32'h14; s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF;
    s_axi_araddr = 32'h08;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    wait_ready(0, "t6");
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    check("t6_pending", {30'b0, s_axi_bvalid, s_axi_rvalid}, 32'b11);
    #2 aresetn = 1'b0;
    #1;
    check("t6_async", {27'b0, s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_arready},
          32'h0);
    check("t6_rdata", s_axi_rdata, 32'h0);
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    @(posedge aclk); @(posedge aclk); #1;
    check("t6_held", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'b000);
    #1 aresetn = 1'b1;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    check("t6_ready", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'b111);
    for (int i = 0; i < NREGS; i++) do_read("t6_zero", 32'(i * 4));

    check("sb_empty", 32'(exp_b.size() + exp_r.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axilite_s_regbank.md
Name: axilite_s_regbank

Overview:
- AXI4-Lite slave register bank that sits directly downstream of the FSM-based AXI-Lite master (axilite_m) and answers its write and read transactions.
- Holds NUM_REGS 32-bit registers. Write and read channels run as independent FSMs.
- Gives the master a real, protocol-correct target, replacing hand-driven ready/valid stimulus. Master timeouts therefore come only from genuine slave backpressure.

Parameters:
- ADDR_W, 32: width of awaddr/araddr.
- NUM_REGS, 16: number of 32-bit registers, power of two, minimum 2. IDX_W = clog2(NUM_REGS).

Ports:
- s_axi_aclk  in  1  clock, all logic on rising edge
- s_axi_aresetn  in  1  asynchronous active-low reset
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_awaddr  in  ADDR_W  write byte address
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables; bit n enables byte n (bits 8n+7:8n)
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_bresp  out  2  write response
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_araddr  in  ADDR_W  read byte address
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response

Behaviour:
Clock and reset:
- One clock, s_axi_aclk.
- Reset s_axi_aresetn is asynchronous and active-low.
- While reset is low: all registers = 0; awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 0.
- All outputs are registered. The first rising edge after reset release sets awready, wready and arready to 1, and both FSMs go to idle.

Addressing:
- Register index = addr[IDX_W+1:2]; addr[1:0] are ignored.
- An address is in range when addr[ADDR_W-1:2] < NUM_REGS. Out-of-range handling is defined under Optional Feature.

Write FSM, states WIDLE / WAIT_W / WAIT_AW / WRESP:
- WIDLE (awready=1, wready=1):
  - awvalid and wvalid together: capture both, commit write on that edge, bvalid<=1, awready<=0, wready<=0, go to WRESP.
  - awvalid only: latch address, awready<=0, go to WAIT_W.
  - wvalid only: latch wdata/wstrb, wready<=0, go to WAIT_AW.
- WAIT_W / WAIT_AW: wait for the missing channel's handshake, then commit, bvalid<=1, drop the remaining ready, go to WRESP.
- Write commit: for each n with wstrb[n]=1, reg[idx] byte n <= wdata byte n; other bytes are unchanged. wstrb=0 still completes with OKAY and changes nothing.
- WRESP: bvalid and bresp are held stable until bready. On the bvalid&bready edge: bvalid<=0, awready<=1, wready<=1, go to WIDLE.
- Minimum spacing is 2 cycles per write: handshake at edge N, bvalid visible cycle N+1, readies back the cycle after the B handshake.
- No second address or data is accepted until the B handshake completes.

Read FSM, states RIDLE / RDATA:
- RIDLE (arready=1): on arvalid: rdata<=reg[idx], rresp set, rvalid<=1, arready<=0, go to RDATA.
- RDATA: rdata and rresp are held stable until rready. On the rvalid&rready edge: rvalid<=0, rdata<=0, arready<=1, go to RIDLE.
- Read latency is 1 cycle from the AR handshake to rvalid.

Boundary conditions:
- Simultaneous read and write committing to the same register on the same edge: the read returns the pre-write value.
- The read and write FSMs never stall each other.
- Reset asserted mid-transaction: immediate return to reset values. The pending transaction is lost and no response is issued.
- awprot/arprot are not present and are never checked.

Optional Feature:
Macro: AXIL_S_DECERR_EN.
- Defined (out-of-range address):
  - write is discarded and bresp=2'b11 (DECERR);
  - read returns rdata=0 with rresp=2'b11;
  - in-range accesses respond 2'b00.
- Undefined: no range check. Upper bits addr[ADDR_W-1:IDX_W+2] are ignored, so accesses alias onto reg[idx], and every response is 2'b00.

Test Plan:
1. Write awaddr=0x08, wdata=0xDEADBEEF, wstrb=0xF with AW and W in the same cycle, bready=1 -> bvalid one cycle after the handshake, bresp=00. Then read 0x08 -> rvalid one cycle after AR, rdata=0xDEADBEEF, rresp=00.
2. reg at 0x04 = 0x11223344; write 0xAABBCCDD with wstrb=0x5 -> read 0x04 returns 0x11BB33DD.
3. wvalid 3 cycles before awvalid to 0x0C -> wready low after the W handshake, awready still 1, bvalid only after the AW handshake, reg[3] updated.
4. bready held low 5 cycles and rready held low 5 cycles -> bvalid/bresp and rvalid/rdata stable throughout; a new awvalid and arvalid are not accepted until each handshake completes.
5. NUM_REGS=16: write 0x55 to 0x40, then read 0x40 and 0x00 -> with macro: bresp=11, rresp=11, rdata=0, reg[0] unchanged; without macro: bresp=00, and reads of both 0x40 and 0x00 return 0x55.
6. Pull s_axi_aresetn low while bvalid=1 and rvalid=1 -> both drop to 0 immediately (asynchronous). After release, all readies are 1 on the first edge and every register reads 0x00000000.
